// File: rtl/qu_common_pkg.sv
// ----------------------------------------------------------------------------
// qu_common
//    Shared definitions for the Qu front-end control slice.
//    Contents:
//       QU_PC_WIDTH         default program-counter width
//       QU_FE_FLUSH_CYCLES  default number of cycles the front end is held off
//                           after a redirect
//       fe_ctrl_state_t     sequencing states of front_end_ctrl
// ----------------------------------------------------------------------------
package qu_common;

   localparam int QU_PC_WIDTH        = 32;
   localparam int QU_FE_FLUSH_CYCLES = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WARM  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } fe_ctrl_state_t;

endpackage : qu_common

// File: rtl/front_end_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// qu_sat_counter
//    Up-counter that sticks at its all-ones value instead of wrapping.
//    Parameters:
//       WIDTH  counter width in bits
//    Ports:
//       clk    in   clock
//       rst    in   synchronous active-high reset, clears the count
//       inc    in   advance the count by one this cycle
//       count  out  current count
// ----------------------------------------------------------------------------
module qu_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Increment only while there is headroom left, so the counter parks at
   // all-ones once it gets there.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : qu_sat_counter

// File: rtl/front_end_ctrl.sv
// ----------------------------------------------------------------------------
// front_end_ctrl
//    Sequencing controller for the Qu front end. Brings fetch then decode up
//    after start, arbitrates back-end redirects (exception > branch > jump),
//    holds the front end in a timed flush after each redirect, and turns
//    downstream fullness into per-stage stalls.
//
//    Parameters:
//       PC_WIDTH      width of the PC override
//       FLUSH_CYCLES  cycles the front end stays disabled after a redirect (>=1)
//
//    Ports:
//       clk, rst                      clock, synchronous active-high reset
//       start                         begin fetching (only looked at in IDLE)
//       exc_req / exc_target          exception redirect request and target
//       br_req  / br_target           branch-mispredict request and target
//       jmp_req / jmp_target          jump request and target
//       if_id_full, id_mp_full,
//       mp_rn_full, rob_full,
//       res_st_full                   downstream fullness flags
//       if_en, id_en                  fetch / decode enables
//       exception, branch, jump       one-cycle redirect pulses
//       pc_override                   redirect PC, held until the next redirect
//       if_stall, id_stall,
//       mp_stall, rn_stall            per-stage stalls
//       state                         current FSM state (debug)
//
//    Build option:
//       QU_FE_CTRL_PERF_EN  when defined, adds perf_redirect_cnt and
//                           perf_stall_cycles (32-bit saturating counters).
// ----------------------------------------------------------------------------
module front_end_ctrl
   import qu_common::*;
#(
   parameter int PC_WIDTH     = QU_PC_WIDTH,
   parameter int FLUSH_CYCLES = QU_FE_FLUSH_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                exc_req,
   input  logic [PC_WIDTH-1:0] exc_target,
   input  logic                br_req,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                jmp_req,
   input  logic [PC_WIDTH-1:0] jmp_target,
   input  logic                if_id_full,
   input  logic                id_mp_full,
   input  logic                mp_rn_full,
   input  logic                rob_full,
   input  logic                res_st_full,
   output logic                if_en,
   output logic                id_en,
   output logic                exception,
   output logic                branch,
   output logic                jump,
   output logic [PC_WIDTH-1:0] pc_override,
   output logic                if_stall,
   output logic                id_stall,
   output logic                mp_stall,
   output logic                rn_stall,
   output fe_ctrl_state_t      state
`ifdef QU_FE_CTRL_PERF_EN
   ,
   output logic [31:0]         perf_redirect_cnt,
   output logic [31:0]         perf_stall_cycles
`endif
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   fe_ctrl_state_t      state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PC_WIDTH-1:0] pcOverride_q, pcOverride_d;
   logic                excPulse_q, excPulse_d;
   logic                brPulse_q, brPulse_d;
   logic                jmpPulse_q, jmpPulse_d;
   logic                redirAccept;
   logic                feActive;

   // Redirects are honoured everywhere except IDLE, where the front end has
   // not been started and there is nothing to steer.
   assign redirAccept = (state_q != IDLE) && (exc_req || br_req || jmp_req);

   // Next-state logic. A redirect always wins over the normal progression and
   // reloads the flush counter, which is how a redirect during FLUSH restarts
   // the flush. Only the highest-priority request is recorded; the others are
   // dropped on purpose and must be re-asserted by their owners.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pcOverride_d = pcOverride_q;
      excPulse_d   = 1'b0;
      brPulse_d    = 1'b0;
      jmpPulse_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WARM;
            end
         end
         WARM: begin
            state_d = RUN;
         end
         RUN: begin
            state_d = RUN;
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = WARM;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirAccept) begin
         state_d = FLUSH;
         cnt_d   = FLUSH_LOAD;
         if (exc_req) begin
            excPulse_d   = 1'b1;
            pcOverride_d = exc_target;
         end else if (br_req) begin
            brPulse_d    = 1'b1;
            pcOverride_d = br_target;
         end else begin
            jmpPulse_d   = 1'b1;
            pcOverride_d = jmp_target;
         end
      end
   end

   // State, flush counter, override PC and pulse registers. Reset drops any
   // in-flight redirect and returns the controller to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pcOverride_q <= '0;
         excPulse_q   <= 1'b0;
         brPulse_q    <= 1'b0;
         jmpPulse_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pcOverride_q <= pcOverride_d;
         excPulse_q   <= excPulse_d;
         brPulse_q    <= brPulse_d;
         jmpPulse_q   <= jmpPulse_d;
      end
   end

   // Stage enables follow directly from the state: WARM lets fetch run one
   // cycle ahead of decode so the IF->ID path has something in it.
   assign feActive = (state_q == WARM) || (state_q == RUN);
   assign if_en    = feActive;
   assign id_en    = (state_q == RUN);

   // Stalls ripple backwards: a full stage stalls itself and every stage in
   // front of it. Outside WARM/RUN every stage is held stalled.
   always_comb begin
      rn_stall = 1'b1;
      mp_stall = 1'b1;
      id_stall = 1'b1;
      if_stall = 1'b1;
      if (feActive) begin
         rn_stall = rob_full | res_st_full;
         mp_stall = mp_rn_full | rn_stall;
         id_stall = id_mp_full | mp_stall;
         if_stall = if_id_full | id_stall;
      end
   end

   assign exception   = excPulse_q;
   assign branch      = brPulse_q;
   assign jump        = jmpPulse_q;
   assign pc_override = pcOverride_q;
   assign state       = state_q;

`ifdef QU_FE_CTRL_PERF_EN
   logic stallInRun;

   // Only count fetch stalls while fully running; WARM/FLUSH stalls are
   // expected sequencing, not back-pressure.
   assign stallInRun = (state_q == RUN) && if_stall;

   qu_sat_counter #(
      .WIDTH (32)
   ) u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirAccept),
      .count (perf_redirect_cnt)
   );

   qu_sat_counter #(
      .WIDTH (32)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stallInRun),
      .count (perf_stall_cycles)
   );
`endif

endmodule : front_end_ctrl

// File: tb/tb_front_end_ctrl.sv
// ----------------------------------------------------------------------------
// tb_front_end_ctrl
//    Directed self-checking bench for front_end_ctrl with default parameters
//    (32-bit PC, 3 flush cycles). Expected values are hand-derived from the
//    sequencing rules of the controller.
// ----------------------------------------------------------------------------
module tb_front_end_ctrl;
   import qu_common::*;

   logic                clk;
   logic                rst;
   logic                start;
   logic                exc_req;
   logic [31:0]         exc_target;
   logic                br_req;
   logic [31:0]         br_target;
   logic                jmp_req;
   logic [31:0]         jmp_target;
   logic                if_id_full;
   logic                id_mp_full;
   logic                mp_rn_full;
   logic                rob_full;
   logic                res_st_full;
   logic                if_en;
   logic                id_en;
   logic                exception;
   logic                branch;
   logic                jump;
   logic [31:0]         pc_override;
   logic                if_stall;
   logic                id_stall;
   logic                mp_stall;
   logic                rn_stall;
   fe_ctrl_state_t      state;
`ifdef QU_FE_CTRL_PERF_EN
   logic [31:0]         perf_redirect_cnt;
   logic [31:0]         perf_stall_cycles;
`endif

   int checkCount = 0;
   int errorCount = 0;

   front_end_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .exc_req     (exc_req),
      .exc_target  (exc_target),
      .br_req      (br_req),
      .br_target   (br_target),
      .jmp_req     (jmp_req),
      .jmp_target  (jmp_target),
      .if_id_full  (if_id_full),
      .id_mp_full  (id_mp_full),
      .mp_rn_full  (mp_rn_full),
      .rob_full    (rob_full),
      .res_st_full (res_st_full),
      .if_en       (if_en),
      .id_en       (id_en),
      .exception   (exception),
      .branch      (branch),
      .jump        (jump),
      .pc_override (pc_override),
      .if_stall    (if_stall),
      .id_stall    (id_stall),
      .mp_stall    (mp_stall),
      .rn_stall    (rn_stall),
      .state       (state)
`ifdef QU_FE_CTRL_PERF_EN
      ,
      .perf_redirect_cnt (perf_redirect_cnt),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive the downstream fullness flags {if_id, id_mp, mp_rn, rob, res_st}.
   task automatic applyStimulus(input logic [4:0] fullVec);
      {if_id_full, id_mp_full, mp_rn_full, rob_full, res_st_full} = fullVec;
      #1;
   endtask

   // Compare all four stalls packed {if, id, mp, rn}.
   task automatic checkStalls(input string tag, input logic [3:0] expected);
      checkOutput(tag, {60'd0, if_stall, id_stall, mp_stall, rn_stall}, {60'd0, expected});
   endtask

   // Compare the three pulses packed {exception, branch, jump}.
   task automatic checkPulses(input string tag, input logic [2:0] expected);
      checkOutput(tag, {61'd0, exception, branch, jump}, {61'd0, expected});
   endtask

   typedef struct {
      logic [4:0] full;
      logic [3:0] stalls;
   } stallVec_t;

   stallVec_t stallTable[6];

   initial begin
      stallTable[0] = '{5'b00000, 4'b0000};
      stallTable[1] = '{5'b00010, 4'b1111};
      stallTable[2] = '{5'b01000, 4'b1100};
      stallTable[3] = '{5'b00100, 4'b1110};
      stallTable[4] = '{5'b10000, 4'b1000};
      stallTable[5] = '{5'b00001, 4'b1111};

      rst = 1'b1;
      start = 1'b0;
      exc_req = 1'b0;
      br_req = 1'b0;
      jmp_req = 1'b0;
      exc_target = 32'h0;
      br_target = 32'h0;
      jmp_target = 32'h0;
      if_id_full = 1'b0;
      id_mp_full = 1'b0;
      mp_rn_full = 1'b0;
      rob_full = 1'b0;
      res_st_full = 1'b0;

      // Reset values.
      repeat (5) step();
      rst = 1'b0;
      #1;
      checkOutput("rst_state", 64'(state), 64'(IDLE));
      checkOutput("rst_if_en", 64'(if_en), 64'd0);
      checkOutput("rst_id_en", 64'(id_en), 64'd0);
      checkOutput("rst_pc", 64'(pc_override), 64'd0);
      checkPulses("rst_pulses", 3'b000);
      checkStalls("rst_stalls", 4'b1111);
`ifdef QU_FE_CTRL_PERF_EN
      checkOutput("rst_perf_redir", 64'(perf_redirect_cnt), 64'd0);
      checkOutput("rst_perf_stall", 64'(perf_stall_cycles), 64'd0);
`endif

      // Idle stays idle without start.
      step();
      checkOutput("idle_hold", 64'(state), 64'(IDLE));

      // Startup: WARM one cycle after start, RUN one cycle later.
      start = 1'b1;
      step();
      start = 1'b0;
      #1;
      checkOutput("warm_state", 64'(state), 64'(WARM));
      checkOutput("warm_if_en", 64'(if_en), 64'd1);
      checkOutput("warm_id_en", 64'(id_en), 64'd0);
      checkStalls("warm_stalls", 4'b0000);
      step();
      checkOutput("run_state", 64'(state), 64'(RUN));
      checkOutput("run_if_en", 64'(if_en), 64'd1);
      checkOutput("run_id_en", 64'(id_en), 64'd1);

      // Stall chain, zero latency from the fullness inputs.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(stallTable[i].full);
         checkStalls($sformatf("stall_vec%0d", i), stallTable[i].stalls);
      end
      applyStimulus(5'b00000);

      // Branch redirect from RUN.
      br_req = 1'b1;
      br_target = 32'h100;
      step();
      br_req = 1'b0;
      #1;
      checkPulses("br_pulse", 3'b010);
      checkOutput("br_pc", 64'(pc_override), 64'h100);
      checkStalls("flush_stalls", 4'b1111);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         checkOutput($sformatf("br_flush_if_en%0d", i), 64'(if_en), 64'd0);
         checkOutput($sformatf("br_flush_state%0d", i), 64'(state), 64'(FLUSH));
      end
      checkPulses("br_pulse_end", 3'b000);
      step();
      checkOutput("br_warm", 64'(state), 64'(WARM));
      checkOutput("br_warm_id_en", 64'(id_en), 64'd0);
      step();
      checkOutput("br_run", 64'(state), 64'(RUN));
      checkOutput("br_pc_held", 64'(pc_override), 64'h100);

      // Simultaneous requests: exception wins.
      exc_req = 1'b1;
      br_req = 1'b1;
      jmp_req = 1'b1;
      exc_target = 32'h80;
      br_target = 32'h100;
      jmp_target = 32'h200;
      step();
      exc_req = 1'b0;
      br_req = 1'b0;
      jmp_req = 1'b0;
      #1;
      checkPulses("prio_pulse", 3'b100);
      checkOutput("prio_pc", 64'(pc_override), 64'h80);

      // Jump in the second FLUSH cycle restarts the flush.
      step();
      checkPulses("prio_pulse_end", 3'b000);
      checkOutput("flush2_state", 64'(state), 64'(FLUSH));
      jmp_req = 1'b1;
      jmp_target = 32'h40;
      step();
      jmp_req = 1'b0;
      #1;
      checkPulses("jmp_pulse", 3'b001);
      checkOutput("jmp_pc", 64'(pc_override), 64'h40);
      checkOutput("jmp_if_en0", 64'(if_en), 64'd0);
      step();
      checkOutput("jmp_if_en1", 64'(if_en), 64'd0);
      step();
      checkOutput("jmp_if_en2", 64'(if_en), 64'd0);
      step();
      checkOutput("jmp_warm", 64'(state), 64'(WARM));
      step();
      checkOutput("jmp_run", 64'(state), 64'(RUN));

      // Reset in the middle of a flush, with a request pending.
      br_req = 1'b1;
      br_target = 32'h300;
      step();
      br_req = 1'b0;
      #1;
      checkOutput("pre_rst_state", 64'(state), 64'(FLUSH));
`ifdef QU_FE_CTRL_PERF_EN
      checkOutput("pre_rst_perf_redir", 64'(perf_redirect_cnt), 64'd4);
`endif
      rst = 1'b1;
      jmp_req = 1'b1;
      jmp_target = 32'h500;
      step();
      rst = 1'b0;
      jmp_req = 1'b0;
      #1;
      checkOutput("mid_rst_state", 64'(state), 64'(IDLE));
      checkOutput("mid_rst_pc", 64'(pc_override), 64'd0);
      checkOutput("mid_rst_if_en", 64'(if_en), 64'd0);
      checkOutput("mid_rst_id_en", 64'(id_en), 64'd0);
      checkPulses("mid_rst_pulses", 3'b000);
      checkStalls("mid_rst_stalls", 4'b1111);
`ifdef QU_FE_CTRL_PERF_EN
      checkOutput("mid_rst_perf_redir", 64'(perf_redirect_cnt), 64'd0);
      checkOutput("mid_rst_perf_stall", 64'(perf_stall_cycles), 64'd0);
`endif

      // Redirects are ignored in IDLE.
      exc_req = 1'b1;
      exc_target = 32'h999;
      step();
      exc_req = 1'b0;
      #1;
      checkOutput("idle_redir_state", 64'(state), 64'(IDLE));
      checkPulses("idle_redir_pulse", 3'b000);
      checkOutput("idle_redir_pc", 64'(pc_override), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule : tb_front_end_ctrl
